// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Brief   : Power-on / software reset generator. Holds every reset domain
//           for INIT_DELAY+1 cycles, then releases channel 0, 1, ... in
//           order, STAGE_DELAY+1 cycles apart. Also tracks the cause of the
//           last restart and a saturating count of software requests.
// Revision: 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int INIT_DELAY  = 31,
    parameter int STAGE_DELAY = 15,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw_req,
    output logic [CHANNELS-1:0]  rst_out,
    output logic                 done,
    output logic                 cause,
    output logic [CNT_WIDTH-1:0] sw_count
);

    // Channel index needs at least one bit even for a single domain
    localparam int c_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(CHANNELS - 1);

    localparam logic [1:0] c_ASSERT  = 2'd0;
    localparam logic [1:0] c_RELEASE = 2'd1;
    localparam logic [1:0] c_RUN     = 2'd2;

    // Declaration values match the reset values so an FPGA configures
    // straight into the ASSERT state with every domain held.
    logic [1:0]           r_state    = c_ASSERT;
    logic [WIDTH-1:0]     r_cnt      = '0;
    logic [c_IDX_W-1:0]   r_idx      = '0;
    logic [CHANNELS-1:0]  r_rst_out  = '1;
    logic                 r_done     = 1'b0;
    logic                 r_cause    = 1'b0;
    logic [CNT_WIDTH-1:0] r_sw_count = '0;

    logic [1:0]           w_state_nxt;
    logic [WIDTH-1:0]     w_cnt_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [CHANNELS-1:0]  w_rst_nxt;
    logic                 w_done_nxt;
    logic                 w_cause_nxt;
    logic [CNT_WIDTH-1:0] w_sw_count_nxt;

    logic w_init_hit;
    logic w_stage_hit;

    assign w_init_hit  = (r_cnt == WIDTH'(INIT_DELAY));
    assign w_stage_hit = (r_cnt == WIDTH'(STAGE_DELAY));

    // State and output registers; reset outranks a software request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ASSERT;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '1;
            r_done     <= 1'b0;
            r_cause    <= 1'b0;
            r_sw_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_out  <= w_rst_nxt;
            r_done     <= w_done_nxt;
            r_cause    <= w_cause_nxt;
            r_sw_count <= w_sw_count_nxt;
        end
    end

    // Next state, delay counter and channel index
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (sw_req) begin
            w_state_nxt = c_ASSERT;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_ASSERT: begin
                    if (w_init_hit) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = c_IDX_W'(1);
                        w_state_nxt = (CHANNELS == 1) ? c_RUN : c_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_RELEASE: begin
                    if (w_stage_hit) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = c_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_RUN: begin
                    w_cnt_nxt = r_cnt;
                end
                default: begin
                    w_state_nxt = c_ASSERT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        w_rst_nxt      = r_rst_out;
        w_done_nxt     = r_done;
        w_cause_nxt    = r_cause;
        w_sw_count_nxt = r_sw_count;
        if (sw_req) begin
            w_rst_nxt   = '1;
            w_done_nxt  = 1'b0;
            w_cause_nxt = 1'b1;
            if (r_sw_count != '1) begin
                w_sw_count_nxt = r_sw_count + 1'b1;
            end
        end else begin
            case (r_state)
                c_ASSERT: begin
                    w_rst_nxt = '1;
                    if (w_init_hit) begin
                        w_rst_nxt[0] = 1'b0;
                        if (CHANNELS == 1) begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                c_RELEASE: begin
                    if (w_stage_hit) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (r_idx == c_IDX_W'(k)) begin
                                w_rst_nxt[k] = 1'b0;
                            end
                        end
                        if (r_idx == c_LAST_IDX) begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    w_rst_nxt  = '0;
                    w_done_nxt = 1'b1;
                end
                default: begin
                    w_rst_nxt  = '1;
                    w_done_nxt = 1'b0;
                end
            endcase
        end
    end

    assign rst_out  = r_rst_out;
    assign done     = r_done;
    assign cause    = r_cause;
    assign sw_count = r_sw_count;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_sequencer
// Brief   : Scoreboard bench for reset_sequencer. Three instances cover the
//           default build, a single-channel zero-delay build with a 2-bit
//           counter, and a three-channel zero-stage-delay build.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic       reset_a, sw_a;
    logic [3:0] rst_a;
    logic       done_a, cause_a;
    logic [7:0] cnt_a;
    // Instance B: CHANNELS=1, zero delays, CNT_WIDTH=2
    logic       reset_b, sw_b;
    logic [0:0] rst_b;
    logic       done_b, cause_b;
    logic [1:0] cnt_b;
    // Instance C: CHANNELS=3, STAGE_DELAY=0
    logic       reset_c, sw_c;
    logic [2:0] rst_c;
    logic       done_c, cause_c;
    logic [7:0] cnt_c;

    reset_sequencer u_a (
        .clk(clk), .reset(reset_a), .sw_req(sw_a),
        .rst_out(rst_a), .done(done_a), .cause(cause_a), .sw_count(cnt_a)
    );

    reset_sequencer #(
        .CHANNELS(1), .WIDTH(8), .INIT_DELAY(0), .STAGE_DELAY(0), .CNT_WIDTH(2)
    ) u_b (
        .clk(clk), .reset(reset_b), .sw_req(sw_b),
        .rst_out(rst_b), .done(done_b), .cause(cause_b), .sw_count(cnt_b)
    );

    reset_sequencer #(
        .CHANNELS(3), .WIDTH(8), .INIT_DELAY(31), .STAGE_DELAY(0), .CNT_WIDTH(8)
    ) u_c (
        .clk(clk), .reset(reset_c), .sw_req(sw_c),
        .rst_out(rst_c), .done(done_c), .cause(cause_c), .sw_count(cnt_c)
    );

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] rst;
        logic       done;
        logic       cause;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_at(input int id, input int c, input logic [3:0] r,
                             input logic d, input logic cs, input logic [7:0] n,
                             input string nm);
        exp_t e;
        e.cyc = c; e.id = id; e.rst = r; e.done = d; e.cause = cs; e.cnt = n; e.name = nm;
        q.push_back(e);
    endtask

    // Full default-build release sequence after a restart sampled at edge b
    task automatic expect_seq4(input int b, input logic cs, input logic [7:0] n,
                               input string nm);
        expect_at(0, b + 1,  4'b1111, 1'b0, cs, n, {nm, "_hold_start"});
        expect_at(0, b + 31, 4'b1111, 1'b0, cs, n, {nm, "_hold_end"});
        expect_at(0, b + 32, 4'b1110, 1'b0, cs, n, {nm, "_ch0"});
        expect_at(0, b + 47, 4'b1110, 1'b0, cs, n, {nm, "_ch0_hold"});
        expect_at(0, b + 48, 4'b1100, 1'b0, cs, n, {nm, "_ch1"});
        expect_at(0, b + 63, 4'b1100, 1'b0, cs, n, {nm, "_ch1_hold"});
        expect_at(0, b + 64, 4'b1000, 1'b0, cs, n, {nm, "_ch2"});
        expect_at(0, b + 79, 4'b1000, 1'b0, cs, n, {nm, "_ch2_hold"});
        expect_at(0, b + 80, 4'b0000, 1'b1, cs, n, {nm, "_ch3_done"});
        expect_at(0, b + 84, 4'b0000, 1'b1, cs, n, {nm, "_run"});
    endtask

    // Monitor: pops every expectation due this cycle and compares it
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [3:0] ar;
                logic       ad, ac;
                logic [7:0] an;
                case (q[i].id)
                    0:       begin ar = rst_a;          ad = done_a; ac = cause_a; an = cnt_a; end
                    1:       begin ar = {3'b000, rst_b}; ad = done_b; ac = cause_b; an = {6'd0, cnt_b}; end
                    default: begin ar = {1'b0, rst_c};  ad = done_c; ac = cause_c; an = cnt_c; end
                endcase
                checks++;
                if (ar !== q[i].rst || ad !== q[i].done || ac !== q[i].cause || an !== q[i].cnt) begin
                    errors++;
                    $display("FAIL %s @%0d: got rst=%b done=%b cause=%b cnt=%0d, required rst=%b done=%b cause=%b cnt=%0d",
                             q[i].name, cyc, ar, ad, ac, an, q[i].rst, q[i].done, q[i].cause, q[i].cnt);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", q[i].name, q[i].cyc, cyc);
                q.delete(i);
            end
        end
    end

    initial begin
        int r;
        int p;
        int qe;
        reset_a = 1'b1; sw_a = 1'b0;
        reset_b = 1'b1; sw_b = 1'b0;
        reset_c = 1'b1; sw_c = 1'b0;
        expect_at(0, 3, 4'b1111, 1'b0, 1'b0, 8'd0, "reset_state");
        repeat (5) @(negedge clk);

        // Power-on release, cause stays 0
        r = cyc;
        expect_seq4(r, 1'b0, 8'd0, "t1");
        reset_a = 1'b0;
        repeat (85) @(negedge clk);

        // Software request from RUN
        p = cyc + 1;
        expect_at(0, p, 4'b1111, 1'b0, 1'b1, 8'd1, "t2_restart");
        expect_seq4(p, 1'b1, 8'd1, "t2");
        sw_a = 1'b1;
        @(negedge clk);
        sw_a = 1'b0;
        repeat (85) @(negedge clk);

        // Software request mid-sequence, after ch0 and ch1 released
        reset_a = 1'b1;
        repeat (2) @(negedge clk);
        r = cyc;
        reset_a = 1'b0;
        p = r + 55;
        expect_at(0, r + 54, 4'b1100, 1'b0, 1'b0, 8'd0, "t3_before");
        expect_at(0, p,      4'b1111, 1'b0, 1'b1, 8'd1, "t3_restart");
        expect_at(0, p + 31, 4'b1111, 1'b0, 1'b1, 8'd1, "t3_hold_end");
        expect_at(0, p + 32, 4'b1110, 1'b0, 1'b1, 8'd1, "t3_ch0");
        expect_at(0, p + 48, 4'b1100, 1'b0, 1'b1, 8'd1, "t3_ch1");
        expect_at(0, p + 64, 4'b1000, 1'b0, 1'b1, 8'd1, "t3_ch2");
        expect_at(0, p + 70, 4'b1000, 1'b0, 1'b1, 8'd1, "t4_before");
        repeat (54) @(negedge clk);
        sw_a = 1'b1;
        @(negedge clk);
        sw_a = 1'b0;
        repeat (70) @(negedge clk);

        // Reset mid-sequence, then reset and sw_req together
        qe = cyc + 1;
        expect_at(0, qe, 4'b1111, 1'b0, 1'b0, 8'd0, "t4_reset");
        reset_a = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 3; i++)
            expect_at(0, qe + i, 4'b1111, 1'b0, 1'b0, 8'd0, "t4_both");
        sw_a = 1'b1;
        repeat (3) @(negedge clk);
        r = cyc;
        expect_seq4(r, 1'b0, 8'd0, "t4_after");
        reset_a = 1'b0;
        sw_a = 1'b0;
        repeat (85) @(negedge clk);

        // Single channel, zero delays: release one edge after reset
        r = cyc;
        expect_at(1, r + 1, 4'b0000, 1'b1, 1'b0, 8'd0, "t6_single_release");
        reset_b = 1'b0;
        repeat (2) @(negedge clk);

        // Saturating 2-bit software counter
        for (int i = 0; i < 5; i++) begin
            logic [7:0] n;
            n = (i + 1 > 3) ? 8'd3 : 8'(i + 1);
            p = cyc + 1;
            expect_at(1, p,     4'b0001, 1'b0, 1'b1, n, "t5_sw_assert");
            expect_at(1, p + 1, 4'b0000, 1'b1, 1'b1, n, "t5_sw_release");
            sw_b = 1'b1;
            @(negedge clk);
            sw_b = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Three channels, zero stage delay: back-to-back releases
        r = cyc;
        expect_at(2, r + 31, 4'b0111, 1'b0, 1'b0, 8'd0, "t6_c_hold");
        expect_at(2, r + 32, 4'b0110, 1'b0, 1'b0, 8'd0, "t6_c_ch0");
        expect_at(2, r + 33, 4'b0100, 1'b0, 1'b0, 8'd0, "t6_c_ch1");
        expect_at(2, r + 34, 4'b0000, 1'b1, 1'b0, 8'd0, "t6_c_ch2_done");
        expect_at(2, r + 38, 4'b0000, 1'b1, 1'b0, 8'd0, "t6_c_run");
        reset_c = 1'b0;
        repeat (42) @(negedge clk);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d pending expectations, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
